modp_mult_sched: RTL and testbench

//  Round-robin scheduler sharing one mult_modp instance (p = 2^255-19) among NREQ requesters.

---
 rtl/modp_mult_sched.sv | 219 +++++++++++++++++++++
 tb/tb_modp_mult_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modp_mult_sched.sv
// modp_mult_sched: round-robin scheduler that shares one mult_modp
// (p = 2^255-19) between NREQ requesters. A request is granted, its operands
// are captured, and the multiplier is restarted by one cycle of inverted
// operands. When data-ready arrives the product goes back to the owner.
// Optional feature: define MODP_SCHED_TIMEOUT_EN to end an operation with an
// error response after TIMEOUT busy cycles without data-ready.
module modp_mult_sched #(
  parameter int N       = 255,
  parameter int NREQ    = 4,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] op_x,
  input  logic [NREQ*N-1:0] op_y,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              m_en,
  output logic [N-1:0]      m_x,
  output logic [N-1:0]      m_y,
  input  logic              m_dr,
  input  logic [N-1:0]      m_prod
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(TIMEOUT) + 1;
  localparam logic [PW-1:0] LAST_SLOT = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_W    = (PW+1)'(NREQ);
  localparam logic [BW-1:0] GUARD_CNT = BW'(GUARD);
  localparam logic [BW-1:0] BCNT_MAX  = {BW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KICK = 2'd1,
    S_BUSY = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [PW-1:0]   ptr_r, ptr_nxt_s;
  logic [PW-1:0]   owner_r, owner_nxt_s;
  logic [BW-1:0]   bcnt_r, bcnt_nxt_s;
  logic [N-1:0]    x_cap_r, x_cap_nxt_s;
  logic [N-1:0]    y_cap_r, y_cap_nxt_s;
  logic [NREQ-1:0] gnt_r, gnt_nxt_s;
  logic [NREQ-1:0] rsp_valid_r, rsp_valid_nxt_s;
  logic [N-1:0]    rsp_data_r, rsp_data_nxt_s;
  logic            rsp_err_r, rsp_err_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            m_en_r, m_en_nxt_s;
  logic [N-1:0]    m_x_r, m_x_nxt_s;
  logic [N-1:0]    m_y_r, m_y_nxt_s;

  logic [PW-1:0]   win_s;
  logic            hit_s;
  logic [PW:0]     sum_s;
  logic [PW-1:0]   scan_s;
  logic            dr_ok_s;
  logic            tmo_hit_s;
  logic [N-1:0]    x_arr_s [NREQ];
  logic [N-1:0]    y_arr_s [NREQ];

  function automatic logic [NREQ-1:0] slot_onehot(input logic [PW-1:0] s);
    slot_onehot = {{(NREQ-1){1'b0}}, 1'b1} << s;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign x_arr_s[g] = op_x[g*N +: N];
    assign y_arr_s[g] = op_y[g*N +: N];
  end

  // A stale data-ready from the previous operation is ignored for GUARD cycles.
  assign dr_ok_s = m_dr && (bcnt_r >= GUARD_CNT);

`ifdef MODP_SCHED_TIMEOUT_EN
  localparam logic [BW-1:0] TMO_LAST = BW'(TIMEOUT - 1);
  assign tmo_hit_s = (bcnt_r == TMO_LAST);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Round-robin winner: first request found scanning upward from ptr, wrapping.
  always_comb begin
    hit_s  = 1'b0;
    win_s  = '0;
    sum_s  = '0;
    scan_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_r} + (PW+1)'(k);
      if (sum_s >= NREQ_W) begin
        scan_s = PW'(sum_s - NREQ_W);
      end else begin
        scan_s = PW'(sum_s);
      end
      if (!hit_s && req[scan_s]) begin
        hit_s = 1'b1;
        win_s = scan_s;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt_s     = state_r;
    ptr_nxt_s       = ptr_r;
    owner_nxt_s     = owner_r;
    bcnt_nxt_s      = bcnt_r;
    x_cap_nxt_s     = x_cap_r;
    y_cap_nxt_s     = y_cap_r;
    gnt_nxt_s       = '0;
    rsp_valid_nxt_s = '0;
    rsp_data_nxt_s  = rsp_data_r;
    rsp_err_nxt_s   = rsp_err_r;
    m_en_nxt_s      = m_en_r;
    m_x_nxt_s       = m_x_r;
    m_y_nxt_s       = m_y_r;
    case (state_r)
      S_IDLE: begin
        if (hit_s) begin
          gnt_nxt_s   = slot_onehot(win_s);
          owner_nxt_s = win_s;
          x_cap_nxt_s = x_arr_s[win_s];
          y_cap_nxt_s = y_arr_s[win_s];
          // Inverted operands during KICK guarantee the multiplier sees a change.
          m_x_nxt_s   = ~x_arr_s[win_s];
          m_y_nxt_s   = ~y_arr_s[win_s];
          m_en_nxt_s  = 1'b0;
          ptr_nxt_s   = (win_s == LAST_SLOT) ? '0 : win_s + PW'(1);
          state_nxt_s = S_KICK;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_KICK: begin
        m_x_nxt_s   = x_cap_r;
        m_y_nxt_s   = y_cap_r;
        m_en_nxt_s  = 1'b1;
        bcnt_nxt_s  = '0;
        state_nxt_s = S_BUSY;
      end
      S_BUSY: begin
        if (dr_ok_s) begin
          rsp_data_nxt_s  = m_prod;
          rsp_err_nxt_s   = 1'b0;
          rsp_valid_nxt_s = slot_onehot(owner_r);
          m_en_nxt_s      = 1'b0;
          state_nxt_s     = S_RESP;
        end else if (tmo_hit_s) begin
          rsp_data_nxt_s  = '0;
          rsp_err_nxt_s   = 1'b1;
          rsp_valid_nxt_s = slot_onehot(owner_r);
          m_en_nxt_s      = 1'b0;
          state_nxt_s     = S_RESP;
        end else begin
          bcnt_nxt_s = (bcnt_r == BCNT_MAX) ? bcnt_r : bcnt_r + BW'(1);
        end
      end
      S_RESP: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != S_IDLE);
  end

  // State and output registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ptr_r       <= '0;
      owner_r     <= '0;
      bcnt_r      <= '0;
      x_cap_r     <= '0;
      y_cap_r     <= '0;
      gnt_r       <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      m_en_r      <= 1'b0;
      m_x_r       <= '0;
      m_y_r       <= '0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      owner_r     <= owner_nxt_s;
      bcnt_r      <= bcnt_nxt_s;
      x_cap_r     <= x_cap_nxt_s;
      y_cap_r     <= y_cap_nxt_s;
      gnt_r       <= gnt_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      busy_r      <= busy_nxt_s;
      m_en_r      <= m_en_nxt_s;
      m_x_r       <= m_x_nxt_s;
      m_y_r       <= m_y_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;
  assign m_en      = m_en_r;
  assign m_x       = m_x_r;
  assign m_y       = m_y_r;

endmodule

// File: tb/tb_modp_mult_sched.sv
// Testbench for modp_mult_sched: behavioural mult_modp model, grant and
// response scoreboards, a vector table of single operations and hand-written
// sequences for arbitration, reset and busy-limit behaviour.
`timescale 1ns/1ps
module tb_modp_mult_sched;

  localparam int N    = 255;
  localparam int NREQ = 4;
  localparam int TMO  = 64;
  localparam int LAT  = 20;
  localparam logic [N-1:0] P = {{(N-8){1'b1}}, 8'hED};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] op_x = '0;
  logic [NREQ*N-1:0] op_y = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [N-1:0]      rsp_data, m_x, m_y;
  logic              rsp_err, busy, m_en;
  logic              m_dr = 1'b0;
  logic [N-1:0]      m_prod = '0;

  int checks = 0;
  int fails  = 0;

  typedef struct { int slot; logic [N-1:0] x; } gexp_t;
  typedef struct { int slot; logic [N-1:0] data; logic err; } rexp_t;
  typedef struct { int slot; logic [N-1:0] x; logic [N-1:0] y; logic [N-1:0] exp; bit stl; } vec_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t gm;
  rexp_t rm;
  vec_t  tbl[5];
  int    rearm[NREQ];
  bit    mdr_hold = 1'b0;
  bit    stale    = 1'b0;

  always #5 clk = ~clk;

  modp_mult_sched #(.N(N), .NREQ(NREQ), .GUARD(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .op_x(op_x), .op_y(op_y),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .m_en(m_en), .m_x(m_x), .m_y(m_y), .m_dr(m_dr), .m_prod(m_prod)
  );

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] t;
    logic [2*N-1:0] pw;
    t  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    pw = {{N{1'b0}}, P};
    t  = t % pw;
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] onehot(input int s);
    return N'(1) << s;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Multiplier model: restarts on any operand change or while disabled, ready LAT cycles later.
  logic [N-1:0] px = '0, py = '0;
  int mcnt = 0;
  always @(posedge clk) begin
    px <= m_x;
    py <= m_y;
    if (!m_en || m_x != px || m_y != py || mdr_hold) begin
      mcnt   <= 0;
      m_dr   <= stale;
      m_prod <= stale ? {{(N-16){1'b0}}, 16'hBAD0} : '0;
    end else if (mcnt >= LAT - 1) begin
      m_dr   <= 1'b1;
      m_prod <= mulmod(m_x, m_y);
    end else begin
      mcnt <= mcnt + 1;
      m_dr <= 1'b0;
    end
  end

  // Grant and response monitors against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst && gnt != '0) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", N'(gnt), '0);
      end else begin
        gm = gq.pop_front();
        chk("gnt_slot", N'(gnt), onehot(gm.slot));
        chk("kick_m_x", m_x, ~gm.x);
        chk("kick_m_en", N'(m_en), '0);
      end
    end
    if (!rst && rsp_valid != '0) begin
      if (rq.size() == 0) begin
        chk("rsp_unexpected", N'(rsp_valid), '0);
      end else begin
        rm = rq.pop_front();
        chk("rsp_slot", N'(rsp_valid), onehot(rm.slot));
        chk("rsp_data", rsp_data, rm.data);
        chk("rsp_err", N'(rsp_err), N'(rm.err));
      end
    end
  end

  // One cycle; requesters drop req in their gnt cycle unless re-arming.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        if (rearm[i] > 0) rearm[i] = rearm[i] - 1;
        else req[i] = 1'b0;
      end
    end
  endtask

  task automatic set_ops(input int s, input logic [N-1:0] x, input logic [N-1:0] y);
    op_x[s*N +: N] = x;
    op_y[s*N +: N] = y;
  endtask

  task automatic expect_op(input int s, input logic [N-1:0] x, input logic [N-1:0] d, input logic e);
    gq.push_back(gexp_t'{s, x});
    rq.push_back(rexp_t'{s, d, e});
  endtask

  task automatic drain(input int limit, input string name);
    int n;
    n = 0;
    while ((gq.size() != 0 || rq.size() != 0) && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (gq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL %s: timed out with %0d grants and %0d responses outstanding, required 0",
               name, gq.size(), rq.size());
      gq.delete();
      rq.delete();
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    for (int i = 0; i < NREQ; i++) rearm[i] = 0;
    tbl[0] = vec_t'{0, N'(3), N'(5), N'(15), 1'b0};
    tbl[1] = vec_t'{3, P - N'(1), N'(2), P - N'(2), 1'b0};
    tbl[2] = vec_t'{2, P - N'(1), P - N'(1), N'(1), 1'b0};
    tbl[3] = vec_t'{1, N'(1) << 254, N'(2), N'(19), 1'b0};
    tbl[4] = vec_t'{0, N'(6), N'(7), N'(42), 1'b1};

    // Reset state.
    repeat (3) step();
    chk("rst_gnt", N'(gnt), '0);
    chk("rst_rsp_valid", N'(rsp_valid), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_err", N'(rsp_err), '0);
    chk("rst_busy", N'(busy), '0);
    chk("rst_m_en", N'(m_en), '0);
    chk("rst_m_x", m_x, '0);
    chk("rst_m_y", m_y, '0);
    rst = 1'b0;
    step();

    // All four requesting right after reset: grants 0,1,2,3.
    for (int i = 0; i < NREQ; i++) begin
      set_ops(i, N'(i + 2), N'(7));
      expect_op(i, N'(i + 2), N'(7 * (i + 2)), 1'b0);
    end
    req = 4'b1111;
    drain(600, "all_four_drain");

    // Slots 0 and 2 re-requesting: 0,2,0,2,0,2.
    set_ops(0, N'(4), N'(3));
    set_ops(2, N'(5), N'(3));
    rearm[0] = 2;
    rearm[2] = 2;
    for (int k = 0; k < 3; k++) begin
      expect_op(0, N'(4), N'(12), 1'b0);
      expect_op(2, N'(5), N'(15), 1'b0);
    end
    req = 4'b0101;
    drain(900, "rr_pair_drain");

    // Single-operation vector table.
    foreach (tbl[v]) begin
      stale = tbl[v].stl;
      set_ops(tbl[v].slot, tbl[v].x, tbl[v].y);
      expect_op(tbl[v].slot, tbl[v].x, tbl[v].exp, 1'b0);
      req[tbl[v].slot] = 1'b1;
      step();
      chk("gnt_latency", N'(gnt), onehot(tbl[v].slot));
      drain(200, "tbl_drain");
      chk("busy_after_rsp", N'(busy), '0);
      stale = 1'b0;
    end

    // Same operands twice back-to-back from slot 1.
    set_ops(1, N'(9), N'(9));
    rearm[1] = 1;
    expect_op(1, N'(9), N'(81), 1'b0);
    expect_op(1, N'(9), N'(81), 1'b0);
    req = 4'b0010;
    drain(300, "repeat_drain");

    // Reset during BUSY drops the operation and clears the pointer.
    set_ops(2, N'(11), N'(13));
    expect_op(2, N'(11), N'(143), 1'b0);
    req = 4'b0100;
    step();
    repeat (6) step();
    chk("pre_rst_busy", N'(busy), N'(1));
    rst = 1'b1;
    void'(rq.pop_back());
    step();
    chk("mid_rst_gnt", N'(gnt), '0);
    chk("mid_rst_rsp_valid", N'(rsp_valid), '0);
    chk("mid_rst_rsp_data", rsp_data, '0);
    chk("mid_rst_busy", N'(busy), '0);
    chk("mid_rst_m_en", N'(m_en), '0);
    chk("mid_rst_m_x", m_x, '0);
    chk("mid_rst_m_y", m_y, '0);
    rst = 1'b0;
    repeat (30) step();
    set_ops(3, N'(6), N'(6));
    expect_op(2, N'(11), N'(143), 1'b0);
    expect_op(3, N'(6), N'(36), 1'b0);
    req = 4'b1100;
    drain(300, "post_rst_drain");

    // Data-ready withheld.
    mdr_hold = 1'b1;
    set_ops(0, N'(2), N'(3));
`ifdef MODP_SCHED_TIMEOUT_EN
    expect_op(0, N'(2), '0, 1'b1);
    req = 4'b0001;
    step();
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      step();
      n++;
    end
    chk("timeout_latency", N'(n), N'(TMO + 1));
    mdr_hold = 1'b0;
    drain(50, "timeout_drain");
`else
    expect_op(0, N'(2), N'(6), 1'b0);
    req = 4'b0001;
    step();
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (!busy || rsp_valid != '0) bad++;
    end
    chk("busy_held_1000", N'(bad), '0);
    mdr_hold = 1'b0;
    drain(200, "late_dr_drain");
`endif
    chk("final_busy", N'(busy), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
